// File: rtl/cic_decim_mc_if.sv
// Sample bus of the multichannel CIC decimator: input samples in, decimated samples out.
// strobe_in / strobe_out are one-cycle qualifiers with no ready. The receiver takes every
// strobed word on the edge where its strobe is high, and nothing can stall the sender.
interface cic_decim_mc_if #(
    parameter int BW  = 16,
    parameter int NCH = 2
);
    logic              strobe_in;
    logic [NCH*BW-1:0] signal_in;
    logic              strobe_out;
    logic [NCH*BW-1:0] signal_out;

    modport master (output strobe_in, signal_in, input strobe_out, signal_out);
    modport slave  (input strobe_in, signal_in, output strobe_out, signal_out);
endinterface

// File: rtl/cic_decim_mc.sv
// N-stage CIC decimator for NCH channels sharing one strobe and one programmable rate.
// Integrators run at the input rate; the comb is a valid-qualified pipeline with round-half-up gain normalisation.
module cic_decim_mc #(
    parameter int BW            = 16,
    parameter int N             = 4,
    parameter int LOG2_MAX_RATE = 7,
    parameter int NCH           = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [LOG2_MAX_RATE:0] rate,
    cic_decim_mc_if.slave          bus
);
    localparam int W  = BW + N * LOG2_MAX_RATE;
    localparam int RW = LOG2_MAX_RATE + 1;
    localparam int SW = $clog2(N * LOG2_MAX_RATE + 1);

    logic [RW-1:0] rl_q, cnt_q, dec_r_q;
    logic          loaded_q, dec_q, samp_v_q, strobe_q;
    logic [W-1:0]  integ_q [NCH][N];
    logic [W-1:0]  integ_d [NCH][N];
    logic [W-1:0]  samp_q  [NCH];
    logic [W-1:0]  comb_q  [NCH][N];
    logic [W-1:0]  dly_q   [NCH][N];
    logic [N-1:0]  comb_v_q;
    logic [SW-1:0] samp_s_q;
    logic [SW-1:0] comb_s_q [N];
    logic [NCH*BW-1:0] out_q, res_w;

    logic [RW-1:0]       rate_n, r_eff;
    logic                wrap;
    logic [W-1:0]        run;
    logic signed [W:0]   wide, half;

    // N * ceil(log2(r)); r is never 0 here
    function automatic logic [SW-1:0] shift_of(input logic [RW-1:0] r);
        logic [RW:0] p;
        int          l;
        p = (RW+1)'(1);
        l = 0;
        for (int i = 0; i < LOG2_MAX_RATE; i++) begin
            if ({1'b0, r} > p) l = i + 1;
            p = p << 1;
        end
        return SW'(l * N);
    endfunction

    // Until the first enabled edge after reset the live rate input stands in for R_l
    assign rate_n = (rate == '0) ? RW'(1) : rate;
    assign r_eff  = loaded_q ? rl_q : rate_n;
    assign wrap   = (cnt_q == r_eff - 1'b1);

    always_comb begin
        run = '0;
        for (int c = 0; c < NCH; c++) begin
            run = {{(W-BW){bus.signal_in[c*BW+BW-1]}}, bus.signal_in[c*BW +: BW]};
            for (int k = 0; k < N; k++) begin
                run           = integ_q[c][k] + run;
                integ_d[c][k] = run;
            end
        end
    end

    always_comb begin
        res_w = '0;
        wide  = '0;
        half  = '0;
        for (int c = 0; c < NCH; c++) begin
            wide = {comb_q[c][N-1][W-1], comb_q[c][N-1]};
            half = '0;
            if (comb_s_q[N-1] != '0) half[comb_s_q[N-1] - 1'b1] = 1'b1;
            wide = (wide + half) >>> comb_s_q[N-1];
            res_w[c*BW +: BW] = wide[BW-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rl_q     <= RW'(1);
            loaded_q <= 1'b0;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            dec_r_q  <= '0;
            samp_v_q <= 1'b0;
            samp_s_q <= '0;
            comb_v_q <= '0;
            strobe_q <= 1'b0;
            out_q    <= '0;
            for (int k = 0; k < N; k++) comb_s_q[k] <= '0;
            for (int c = 0; c < NCH; c++) begin
                samp_q[c] <= '0;
                for (int k = 0; k < N; k++) begin
                    integ_q[c][k] <= '0;
                    comb_q[c][k]  <= '0;
                    dly_q[c][k]   <= '0;
                end
            end
        end else if (!enable) begin
            rl_q     <= rate_n;
            loaded_q <= 1'b1;
            cnt_q    <= '0;
            dec_q    <= 1'b0;
            dec_r_q  <= '0;
            samp_v_q <= 1'b0;
            samp_s_q <= '0;
            comb_v_q <= '0;
            strobe_q <= 1'b0;
            out_q    <= '0;
            for (int k = 0; k < N; k++) comb_s_q[k] <= '0;
            for (int c = 0; c < NCH; c++) begin
                samp_q[c] <= '0;
                for (int k = 0; k < N; k++) begin
                    integ_q[c][k] <= '0;
                    comb_q[c][k]  <= '0;
                    dly_q[c][k]   <= '0;
                end
            end
        end else begin
            loaded_q <= 1'b1;
            if (!loaded_q) rl_q <= rate_n;
            dec_q <= 1'b0;
            if (bus.strobe_in) begin
                for (int c = 0; c < NCH; c++)
                    for (int k = 0; k < N; k++) integ_q[c][k] <= integ_d[c][k];
                if (wrap) begin
                    cnt_q   <= '0;
                    rl_q    <= rate_n;
                    dec_q   <= 1'b1;
                    dec_r_q <= r_eff;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            // Sampler and comb stages advance one slot per cycle behind their valid bits
            samp_v_q <= dec_q;
            if (dec_q) begin
                samp_s_q <= shift_of(dec_r_q);
                for (int c = 0; c < NCH; c++) samp_q[c] <= integ_q[c][N-1];
            end
            comb_v_q[0] <= samp_v_q;
            if (samp_v_q) begin
                comb_s_q[0] <= samp_s_q;
                for (int c = 0; c < NCH; c++) begin
                    comb_q[c][0] <= samp_q[c] - dly_q[c][0];
                    dly_q[c][0]  <= samp_q[c];
                end
            end
            for (int k = 1; k < N; k++) begin
                comb_v_q[k] <= comb_v_q[k-1];
                if (comb_v_q[k-1]) begin
                    comb_s_q[k] <= comb_s_q[k-1];
                    for (int c = 0; c < NCH; c++) begin
                        comb_q[c][k] <= comb_q[c][k-1] - dly_q[c][k];
                        dly_q[c][k]  <= comb_q[c][k-1];
                    end
                end
            end
            strobe_q <= comb_v_q[N-1];
            if (comb_v_q[N-1]) out_q <= res_w;
        end
    end

    assign bus.strobe_out = strobe_q;
    assign bus.signal_out = out_q;
endmodule

// File: tb/tb_cic_decim_mc.sv
// Bench for cic_decim_mc: a sequence-level CIC model (running sums, N-th finite difference of the
// decimated sequence, rounded shift) predicts every output cycle; directed cases pin literal values.
module tb_cic_decim_mc;
  localparam int BW = 16;
  localparam int N = 4;
  localparam int LOG2_MAX_RATE = 7;
  localparam int NCH = 2;
  localparam int W = BW + N * LOG2_MAX_RATE;
  localparam longint MASK = (longint'(1) << W) - 1;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  logic [LOG2_MAX_RATE:0] rate = 8'd8;

  cic_decim_mc_if #(.BW(BW), .NCH(NCH)) bus ();

  cic_decim_mc #(.BW(BW), .N(N), .LOG2_MAX_RATE(LOG2_MAX_RATE), .NCH(NCH)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .rate(rate),
    .bus(bus)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCH*BW-1:0] pk(input int a, input int b);
    logic [NCH*BW-1:0] v;
    v[BW-1:0] = a[BW-1:0];
    v[2*BW-1:BW] = b[BW-1:0];
    return v;
  endfunction

  function automatic int ceil_log2(input int r);
    int l = 0;
    while ((1 << l) < r) l++;
    return l;
  endfunction

  function automatic longint binom(input int n, input int k);
    longint v = 1;
    for (int i = 1; i <= k; i++) v = v * (n - k + i) / i;
    return v;
  endfunction

  // ---------------- reference model ----------------
  longint acc [NCH][N];
  longint dh [NCH][N+1];
  int m_cnt = 0;
  int m_rl = 1;
  bit m_loaded = 1'b0;
  longint cyc = 0;
  logic [NCH*BW-1:0] exp_q[$];
  longint due_q[$];
  logic [NCH*BW-1:0] exp_out = '0;
  logic exp_strobe = 1'b0;

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < N; k++) acc[c][k] = 0;
      for (int j = 0; j <= N; j++) dh[c][j] = 0;
    end
    m_cnt = 0;
    exp_q.delete();
    due_q.delete();
    exp_out = '0;
    exp_strobe = 1'b0;
  endtask

  task automatic model_decimate(input int r);
    logic [NCH*BW-1:0] word;
    longint y;
    int s;
    word = '0;
    s = N * ceil_log2(r);
    for (int c = 0; c < NCH; c++) begin
      for (int j = N; j > 0; j--) dh[c][j] = dh[c][j-1];
      dh[c][0] = acc[c][N-1];
      y = 0;
      for (int j = 0; j <= N; j++) y += ((j % 2) ? -1 : 1) * binom(N, j) * dh[c][j];
      y = y & MASK;
      if (y[W-1]) y = y - (longint'(1) << W);
      if (s > 0) y = y + (longint'(1) << (s - 1));
      y = y >>> s;
      word[c*BW +: BW] = y[BW-1:0];
    end
    exp_q.push_back(word);
    due_q.push_back(cyc + N + 2);
  endtask

  always @(posedge clock or negedge reset_n) begin : model
    int rn, r;
    logic signed [BW-1:0] xs;
    longint run;
    if (!reset_n) begin
      model_clear();
      m_rl = 1;
      m_loaded = 1'b0;
    end else begin
      cyc++;
      rn = (rate == 0) ? 1 : int'(rate);
      if (!enable) begin
        model_clear();
        m_rl = rn;
        m_loaded = 1'b1;
      end else begin
        exp_strobe = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          void'(due_q.pop_front());
          exp_out = exp_q.pop_front();
          exp_strobe = 1'b1;
        end
        r = m_loaded ? m_rl : rn;
        if (!m_loaded) m_rl = rn;
        m_loaded = 1'b1;
        if (bus.strobe_in) begin
          for (int c = 0; c < NCH; c++) begin
            xs = bus.signal_in[c*BW +: BW];
            run = longint'(xs) & MASK;
            for (int k = 0; k < N; k++) begin
              acc[c][k] = (acc[c][k] + run) & MASK;
              run = acc[c][k];
            end
          end
          if (m_cnt == r - 1) begin
            m_cnt = 0;
            m_rl = rn;
            model_decimate(r);
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    check("strobe_out", 64'(bus.strobe_out), 64'(exp_strobe));
    check("signal_out", 64'(bus.signal_out), 64'(exp_out));
  end

  // ---------------- output monitor for directed checks ----------------
  longint last_out_cyc = 0;
  longint last_gap = 0;
  logic [NCH*BW-1:0] last_val = '0;
  bit rec = 1'b0;
  longint gap_q[$];
  longint ocyc_q[$];
  logic [NCH*BW-1:0] val_q[$];

  always @(negedge clock) begin
    if (bus.strobe_out) begin
      last_gap = cyc - last_out_cyc;
      last_out_cyc = cyc;
      last_val = bus.signal_out;
      if (rec) begin
        gap_q.push_back(last_gap);
        ocyc_q.push_back(cyc);
        val_q.push_back(bus.signal_out);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic clear_pipe(input logic [LOG2_MAX_RATE:0] r);
    enable = 1'b0;
    rate = r;
    bus.strobe_in = 1'b0;
    step(1);
    enable = 1'b1;
  endtask

  task automatic wait_out(input int budget, output longint at, output bit seen);
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if (bus.strobe_out) begin
        seen = 1'b1;
        at = cyc;
      end
    end
  endtask

  logic [LOG2_MAX_RATE:0] rate_tab [10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd8, 8'd16, 8'd100, 8'd128};

  initial begin
    longint f, at, in_edge;
    bit seen;
    logic [NCH*BW-1:0] rnd;
    int pct;

    bus.strobe_in = 1'b0;
    bus.signal_in = '0;

    // reset state
    #1 reset_n = 1'b0;
    #1;
    check("reset_strobe", 64'(bus.strobe_out), 64'd0);
    check("reset_signal", 64'(bus.signal_out), 64'd0);
    step(3);
    reset_n = 1'b1;

    // DC +/-100 at R=8, strobe every cycle
    enable = 1'b1;
    bus.strobe_in = 1'b1;
    bus.signal_in = pk(100, -100);
    step(96);
    check("dc8_value", 64'(last_val), 64'(pk(100, -100)));
    check("dc8_period", 64'(last_gap), 64'd8);
    check("dc8_model", 64'(exp_out), 64'(pk(100, -100)));

    // DC 1000 at R=5: S=12, gain 625/4096
    clear_pipe(8'd5);
    bus.strobe_in = 1'b1;
    bus.signal_in = pk(1000, 1000);
    step(75);
    check("dc5_value", 64'(last_val), 64'(pk(153, 153)));
    check("dc5_model", 64'(exp_out), 64'(pk(153, 153)));
    check("dc5_period", 64'(last_gap), 64'd5);

    // Rate 8 -> 4 three strobes into a period
    clear_pipe(8'd8);
    bus.strobe_in = 1'b1;
    bus.signal_in = pk(100, 100);
    step(83);
    rate = 8'd4;
    gap_q.delete();
    rec = 1'b1;
    step(60);
    rec = 1'b0;
    check("rchg_count", 64'(gap_q.size() >= 3), 64'd1);
    if (gap_q.size() >= 3) begin
      check("rchg_gap0", 64'(gap_q[0]), 64'd8);
      check("rchg_gap1", 64'(gap_q[1]), 64'd8);
      check("rchg_gap2", 64'(gap_q[2]), 64'd4);
    end
    check("rchg_value", 64'(last_val), 64'(pk(100, 100)));

    // R=1 ramp, fully pipelined
    clear_pipe(8'd1);
    gap_q.delete();
    ocyc_q.delete();
    val_q.delete();
    rec = 1'b1;
    bus.strobe_in = 1'b1;
    bus.signal_in = pk(0, 0);
    in_edge = cyc + 1;
    for (int i = 1; i < 30; i++) begin
      step(1);
      bus.signal_in = pk(i, -i);
    end
    step(1);
    bus.strobe_in = 1'b0;
    step(12);
    rec = 1'b0;
    check("ramp_count", 64'(val_q.size()), 64'd30);
    if (val_q.size() == 30) begin
      check("ramp_latency", 64'(ocyc_q[0] - in_edge), 64'(N + 2));
      check("ramp_span", 64'(ocyc_q[29] - ocyc_q[0]), 64'd29);
      check("ramp_v0", 64'(val_q[0]), 64'(pk(0, 0)));
      check("ramp_v1", 64'(val_q[1]), 64'(pk(1, -1)));
      check("ramp_v17", 64'(val_q[17]), 64'(pk(17, -17)));
      check("ramp_v29", 64'(val_q[29]), 64'(pk(29, -29)));
    end

    // enable dropped for one cycle with a sample in the comb pipeline
    clear_pipe(8'd8);
    bus.strobe_in = 1'b1;
    bus.signal_in = pk(100, -100);
    step(10);
    enable = 1'b0;
    step(1);
    check("endrop_strobe", 64'(bus.strobe_out), 64'd0);
    check("endrop_signal", 64'(bus.signal_out), 64'd0);
    enable = 1'b1;
    f = cyc + 1;
    wait_out(40, at, seen);
    check("endrop_seen", 64'(seen), 64'd1);
    check("endrop_latency", 64'(at - f), 64'(8 - 1 + N + 2));

    // asynchronous reset pulse between clock edges mid-period
    clear_pipe(8'd8);
    bus.strobe_in = 1'b1;
    bus.signal_in = pk(300, -300);
    step(20);
    #2 reset_n = 1'b0;
    #1;
    check("areset_strobe", 64'(bus.strobe_out), 64'd0);
    check("areset_signal", 64'(bus.signal_out), 64'd0);
    step(2);
    reset_n = 1'b1;
    f = cyc + 1;
    wait_out(40, at, seen);
    check("areset_seen", 64'(seen), 64'd1);
    check("areset_latency", 64'(at - f), 64'(8 - 1 + N + 2));

    // randomized segments: rates incl. 0 and max, sparse/dense strobes, rate changes, enable drops
    for (int seg = 0; seg < 12; seg++) begin
      pct = $urandom_range(20, 100);
      if ($urandom_range(0, 1) == 1) clear_pipe(rate_tab[$urandom_range(0, 9)]);
      else rate = rate_tab[$urandom_range(0, 9)];
      for (int i = 0; i < 350; i++) begin
        for (int c = 0; c < NCH; c++) rnd[c*BW +: BW] = BW'($urandom());
        bus.signal_in = rnd;
        bus.strobe_in = ($urandom_range(0, 99) < pct);
        if ($urandom_range(0, 199) == 0) rate = rate_tab[$urandom_range(0, 9)];
        enable = ($urandom_range(0, 249) != 0);
        if (seg == 5 && i == 100) begin
          #2 reset_n = 1'b0;
          #3 reset_n = 1'b1;
        end
        step(1);
      end
    end

    bus.strobe_in = 1'b0;
    enable = 1'b1;
    step(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cic_decim_mc.md
CIC_DECIM_MC -- requirements
Module: cic_decim_mc

Interface
REQ-001 Parameter BW, default 16, sample width per channel (two's complement).
REQ-002 Parameter N, default 4, number of integrator and comb stages.
REQ-003 Parameter LOG2_MAX_RATE, default 7, log2 of the maximum decimation rate.
REQ-004 Parameter NCH, default 2, number of channels sharing one strobe and one rate.
REQ-005 clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  synchronous run/clear; low clears datapath state.
REQ-008 rate  input  LOG2_MAX_RATE+1  decimation rate R, valid range 1..2^LOG2_MAX_RATE; 0 treated as 1.
REQ-009 strobe_in  input  1  one-cycle qualifier that a new input sample is present.
REQ-010 signal_in  input  NCH*BW  channel c occupies bits [c*BW +: BW].
REQ-011 strobe_out  output  1  one-cycle pulse marking a new signal_out value.
REQ-012 signal_out  output  NCH*BW  decimated, gain-normalised output, same packing as signal_in.

Function
REQ-013 Internal width W SHALL be BW+N*LOG2_MAX_RATE; each channel's input SHALL be sign-extended to W.
REQ-014 Each channel SHALL have N cascaded integrators; all update on every edge with strobe_in=1 and enable=1, wrapping modulo 2^W.
REQ-015 A phase counter, 0..R_l-1, SHALL advance on each accepted strobe_in; R_l is the latched rate.
REQ-016 On an accepted strobe_in with counter = R_l-1 (the wrap edge E):
- counter SHALL return to 0;
- R_l SHALL be reloaded from rate;
- an internal decimation pulse SHALL be registered.
REQ-017 A change on rate SHALL take effect only at the next wrap edge; the current decimation period SHALL complete at the old rate.
REQ-018 At edge E+1 each channel's sampler SHALL capture integrator N-1, which then includes the sample accepted at E.
REQ-019 Comb stage k (k=0..N-1) SHALL update at edge E+2+k:
- out_k = in_k - delay_k;
- delay_k <= in_k;
- a valid bit SHALL travel with the data; stages SHALL NOT update without it.
REQ-020 Shift S SHALL be N*ceil(log2(R)), using R latched with the sample; S=0 when R=1.
REQ-021 The comb output SHALL be rounded half-up: add 2^(S-1) when S>0, then arithmetic right shift by S.
REQ-022 The rounded value SHALL be truncated to BW bits.
- DC gain is R^N/2^S: exactly 1 for power-of-two R, below 1 otherwise.
REQ-023 At edge E+N+2, signal_out SHALL register the result for all channels, and strobe_out SHALL be 1 for exactly one cycle.
- Total latency is N+2 cycles after E.
REQ-024 strobe_in may be asserted on consecutive cycles; with R=1 the block SHALL produce one strobe_out per strobe_in, fully pipelined.
REQ-025 When strobe_in=1 coincides with a pipeline advance, both SHALL occur in the same cycle without loss.
REQ-026 enable=0 SHALL synchronously clear all state:
- integrators, sampler, comb out and delay registers, valid bits, counter;
- signal_out cleared and strobe_out forced to 0;
- R_l loaded from rate.
REQ-027 Samples in flight when enable falls SHALL be discarded; strobe_in SHALL be ignored while enable=0.

Reset
REQ-028 reset_n=0 SHALL immediately, independent of clock, clear:
- all integrator, comb, sampler and counter state and valid bits;
- signal_out to 0 and strobe_out to 0.
- R_l SHALL be set to 1.
REQ-029 After reset_n rises, R_l SHALL load rate on the first clock edge where enable=1, then follow REQ-016.
REQ-030 Reset asserted mid-decimation SHALL discard all partial sums; no strobe_out SHALL follow for pre-reset samples.

Verification
REQ-031 N=4, R=8, DC input 100 on channel 0 and -100 on channel 1, strobe_in every cycle -> after settling, signal_out = {100, -100}; strobe_out exactly every 8 cycles.
REQ-032 R=5, DC input 1000 -> S=12; settled output 153 (1000*625/4096 rounded half-up).
REQ-033 R=1, ramp input 0,1,2,... on consecutive cycles -> output sequence equals the input, each value N+2 cycles after its strobe_in.
REQ-034 R changed 8->4 mid-period -> current period still emits after 8 strobes, subsequent outputs every 4 strobes; DC 100 settles back to 100.
REQ-035 enable dropped for 1 cycle with samples in the comb pipeline -> no strobe_out for those samples; state is zero; the first output after re-enable occurs after R strobes plus N+2 cycles.
REQ-036 reset_n pulsed low between clock edges mid-period -> outputs go to 0 at once; counter restarts at 0 after release.
